serial_bit_source: RTL and testbench
====================================

# serial_bit_source

Upstream stage of the sequence-detector path: accepts parallel words over a valid/ready handshake and serializes them, one bit per clock, onto the single-bit input `a` consumed by the Mealy and Moore detector FSMs. It inserts a configurable idle gap between words so that detector patterns do not straddle word boundaries unless the gap is zero. It also provides `a_valid` and `last` qualifiers for benches and downstream logic.

## Interface

- `WIDTH`, 8: bits per word; legal range 2..32.
- `GAP`, 2: idle cycles inserted after each word; legal range 0..15.
- `IDLE_BIT`, 0: level driven on `a` when no word bit is being sent.
- `MSB_FIRST`, 1: 1 sends din[WIDTH-1] first; 0 sends din[0] first.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `din_valid`  in  1  producer has a word on `din`.
- `din`  in  WIDTH  word to serialize; sampled only on handshake.
- `din_ready`  out  1  block can accept a word this cycle (registered).
- `a`  out  1  serial bit to detector FSMs (registered).
- `a_valid`  out  1  `a` carries a word bit this cycle (registered).
- `last`  out  1  `a` carries the final bit of the word (registered).

## Operation

- States: IDLE, SHIFT, GAP. Reset state is IDLE.
- Handshake: a word is accepted at a rising edge where `din_valid && din_ready`. `din` is ignored at all other edges. `din_valid` without `din_ready` means no capture, and the producer holds.
- IDLE: `din_ready`=1, `a`=IDLE_BIT, `a_valid`=0. On accept: load the shift register and set the bit counter to 0. At that same edge, drive the first bit on `a` with `a_valid`=1, and go to SHIFT.
- SHIFT: at each edge, advance to the next bit (per MSB_FIRST) and increment the counter. `last`=1 while counter==WIDTH-1.
- Leaving SHIFT, at the edge after the last bit:
  - GAP>0: go to GAP. `a`=IDLE_BIT, `a_valid`=0, `last`=0, gap counter=1.
  - GAP==0: go to IDLE.
- GAP: the gap counter increments each edge. After exactly GAP cycles with `a_valid`=0, the state returns to IDLE and `din_ready`=1.
- Back-to-back streaming (GAP==0 only): `din_ready` is also 1 during the last-bit cycle. An accept at that edge loads the new word, and its first bit follows the previous last bit with no bubble; the state stays in SHIFT.
- `din_ready` is 0 in SHIFT, except in the last-bit cycle when GAP==0, and 0 in GAP.
- Counters are sized to hold WIDTH-1 and GAP without wrap. They never wrap mid-word.

## Timing

- Reset values (asynchronous, while `reset`=0): `a`=IDLE_BIT, `a_valid`=0, `last`=0, `din_ready`=0, state IDLE, counters 0.
- After reset deasserts, `din_ready` rises at the first rising edge.
- Latency: accept at edge k puts the first bit on `a` in the cycle after edge k. Bit i is on `a` in cycle k+1+i, and `last` is asserted in cycle k+WIDTH.
- Word period is WIDTH+GAP+1 cycles when GAP>0: WIDTH bit cycles, GAP gap cycles, and one IDLE cycle for the next accept. With GAP==0 and back-to-back accepts, the period is WIDTH cycles.
- Reset asserted mid-word or mid-gap: the partial word is discarded and all outputs go to reset values immediately. After release, no residual bits are emitted.
- All outputs change only on rising `clock` edges or on asynchronous reset. No output depends combinationally on inputs.

## Test plan

- Reset: hold `reset`=0 with `din_valid`=1 -> `a`=0, `a_valid`=0, `din_ready`=0. Release -> `din_ready`=1 after one edge, and no capture occurs until that cycle.
- Single word, defaults, din=8'hB2 -> `a` = 1,0,1,1,0,0,1,0 on 8 consecutive cycles with `a_valid`=1. `last` is high only on the 8th bit. This is followed by 2 cycles of `a`=0, `a_valid`=0, then `din_ready`=1.
- LSB-first, MSB_FIRST=0, din=8'hB2 -> `a` = 0,1,0,0,1,1,0,1.
- Back-to-back, GAP=0, din 8'hFF then 8'h00 with `din_valid` held -> 16 continuous `a_valid` cycles (eight 1s then eight 0s). `last` pulses on cycles 8 and 16, and `din_ready` is high on cycles 8 and 16.
- Backpressure: assert `din_valid` with din=8'h0F during SHIFT, while `din_ready`=0 -> no capture, and the current word completes unchanged. 8'h0F is accepted in the first IDLE cycle.
- Reset mid-word: assert `reset`=0 after 3 bits of 8'hA5 -> outputs go to reset values immediately. After release, `a` stays 0 and `a_valid` stays 0 until a new word is accepted.

Source files
------------

// File: rtl/serial_bit_source_if.sv
// Word-in / bit-out handshake bundle for serial_bit_source.
// The producer drives din_valid/din; the serializer answers with din_ready and the serial stream.
interface serial_bit_source_if #(
  parameter int WIDTH = 8
);
  logic             din_valid;
  logic [WIDTH-1:0] din;
  logic             din_ready;
  logic             a;
  logic             a_valid;
  logic             last;

  modport master (
    output din_valid, din,
    input  din_ready, a, a_valid, last
  );

  modport slave (
    input  din_valid, din,
    output din_ready, a, a_valid, last
  );
endinterface

// File: rtl/serial_bit_source.sv
// Serializes handshaked parallel words onto the single-bit detector input 'a',
// with a configurable idle gap between words and a_valid/last qualifiers.
module serial_bit_source #(
  parameter int WIDTH     = 8,
  parameter int GAP       = 2,
  parameter bit IDLE_BIT  = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  serial_bit_source_if.slave    bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             a_q;
  logic             a_valid_q;
  logic             last_q;
  logic             din_ready_q;

  logic             accept;
  logic [CW-1:0]    next_cnt;

  // shreg holds only the bits not yet driven on 'a'; the head bit goes out at load time.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign accept   = bus.din_valid && din_ready_q;
  assign next_cnt = bit_cnt + 1'b1;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in this block.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      a_q         <= IDLE_BIT;
      a_valid_q   <= 1'b0;
      last_q      <= 1'b0;
      din_ready_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state       <= ST_SHIFT;
            shreg       <= drop_head(bus.din);
            bit_cnt     <= '0;
            a_q         <= head_bit(bus.din);
            a_valid_q   <= 1'b1;
            last_q      <= 1'b0;
            din_ready_q <= 1'b0;
          end else begin
            a_q         <= IDLE_BIT;
            a_valid_q   <= 1'b0;
            last_q      <= 1'b0;
            din_ready_q <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (bit_cnt == LAST_IDX) begin
            if (accept) begin
              // Only reachable with GAP==0: chain the next word with no bubble.
              shreg       <= drop_head(bus.din);
              bit_cnt     <= '0;
              a_q         <= head_bit(bus.din);
              a_valid_q   <= 1'b1;
              last_q      <= 1'b0;
              din_ready_q <= 1'b0;
            end else if (GAP == 0) begin
              state       <= ST_IDLE;
              bit_cnt     <= '0;
              a_q         <= IDLE_BIT;
              a_valid_q   <= 1'b0;
              last_q      <= 1'b0;
              din_ready_q <= 1'b1;
            end else begin
              state       <= ST_GAP;
              bit_cnt     <= '0;
              gap_cnt     <= GW'(1);
              a_q         <= IDLE_BIT;
              a_valid_q   <= 1'b0;
              last_q      <= 1'b0;
              din_ready_q <= 1'b0;
            end
          end else begin
            shreg       <= drop_head(shreg);
            bit_cnt     <= next_cnt;
            a_q         <= head_bit(shreg);
            last_q      <= (next_cnt == LAST_IDX);
            din_ready_q <= (GAP == 0) && (next_cnt == LAST_IDX);
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state       <= ST_IDLE;
            gap_cnt     <= '0;
            din_ready_q <= 1'b1;
          end else begin
            gap_cnt     <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          a_q         <= IDLE_BIT;
          a_valid_q   <= 1'b0;
          last_q      <= 1'b0;
          din_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a         = a_q;
  assign bus.a_valid   = a_valid_q;
  assign bus.last      = last_q;
  assign bus.din_ready = din_ready_q;

endmodule

// File: tb/tb_serial_bit_source.sv
// Directed bench for serial_bit_source: MSB-first/GAP=2, LSB-first/GAP=2 and
// MSB-first/GAP=0 instances share clock and reset; expected streams are hand-computed.
module tb_serial_bit_source;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  serial_bit_source_if #(.WIDTH(8)) m_if ();
  serial_bit_source_if #(.WIDTH(8)) l_if ();
  serial_bit_source_if #(.WIDTH(8)) z_if ();

  serial_bit_source #(.WIDTH(8), .GAP(2), .IDLE_BIT(1'b0), .MSB_FIRST(1'b1)) u_msb (
    .clock (clock), .reset (reset), .bus (m_if)
  );
  serial_bit_source #(.WIDTH(8), .GAP(2), .IDLE_BIT(1'b0), .MSB_FIRST(1'b0)) u_lsb (
    .clock (clock), .reset (reset), .bus (l_if)
  );
  serial_bit_source #(.WIDTH(8), .GAP(0), .IDLE_BIT(1'b0), .MSB_FIRST(1'b1)) u_b2b (
    .clock (clock), .reset (reset), .bus (z_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ready_of(input int which);
    case (which)
      0:       return m_if.din_ready;
      1:       return l_if.din_ready;
      default: return z_if.din_ready;
    endcase
  endfunction

  task automatic wait_ready(input int which);
    int n = 0;
    while (ready_of(which) !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("ready_wait_%0d", which), ready_of(which), 1);
  endtask

  // seq fields list bits in emission order, first bit in [7].
  typedef struct {
    logic [7:0] din;
    logic [7:0] msb_seq;
    logic [7:0] lsb_seq;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    logic [7:0] w2;

    vecs[0] = '{din: 8'hB2, msb_seq: 8'b1011_0010, lsb_seq: 8'b0100_1101};
    vecs[1] = '{din: 8'h3C, msb_seq: 8'b0011_1100, lsb_seq: 8'b0011_1100};
    vecs[2] = '{din: 8'h81, msb_seq: 8'b1000_0001, lsb_seq: 8'b1000_0001};
    vecs[3] = '{din: 8'hE4, msb_seq: 8'b1110_0100, lsb_seq: 8'b0010_0111};
    vecs[4] = '{din: 8'h5A, msb_seq: 8'b0101_1010, lsb_seq: 8'b0101_1010};

    m_if.din_valid = 1'b1; m_if.din = 8'hFF;
    l_if.din_valid = 1'b0; l_if.din = 8'h00;
    z_if.din_valid = 1'b0; z_if.din = 8'h00;

    // Reset held with din_valid asserted.
    repeat (2) @(negedge clock);
    check("rst_a",         m_if.a,         0);
    check("rst_a_valid",   m_if.a_valid,   0);
    check("rst_last",      m_if.last,      0);
    check("rst_din_ready", m_if.din_ready, 0);
    reset = 1'b1;
    @(negedge clock);
    check("rel_din_ready", m_if.din_ready, 1);
    check("rel_no_capture", m_if.a_valid,  0);
    m_if.din_valid = 1'b0;
    @(negedge clock);
    check("rel_idle_a_valid", m_if.a_valid, 0);

    // Table: same word into MSB-first and LSB-first instances, GAP=2.
    for (int v = 0; v < 5; v++) begin
      wait_ready(0);
      check("tbl_lsb_ready", l_if.din_ready, 1);
      m_if.din_valid = 1'b1; m_if.din = vecs[v].din;
      l_if.din_valid = 1'b1; l_if.din = vecs[v].din;
      for (int i = 0; i < 8; i++) begin
        @(negedge clock);
        if (i == 0) begin
          m_if.din_valid = 1'b0;
          l_if.din_valid = 1'b0;
        end
        check($sformatf("tbl%0d_msb_a%0d", v, i), m_if.a,         vecs[v].msb_seq[7-i]);
        check($sformatf("tbl%0d_lsb_a%0d", v, i), l_if.a,         vecs[v].lsb_seq[7-i]);
        check($sformatf("tbl%0d_av%0d", v, i),    m_if.a_valid,   1);
        check($sformatf("tbl%0d_last%0d", v, i),  m_if.last,      (i == 7) ? 1 : 0);
        check($sformatf("tbl%0d_lsb_last%0d", v, i), l_if.last,   (i == 7) ? 1 : 0);
        check($sformatf("tbl%0d_rdy%0d", v, i),   m_if.din_ready, 0);
      end
      for (int g = 0; g < 2; g++) begin
        @(negedge clock);
        check($sformatf("tbl%0d_gap_av%0d", v, g),  m_if.a_valid,   0);
        check($sformatf("tbl%0d_gap_a%0d", v, g),   m_if.a,         0);
        check($sformatf("tbl%0d_gap_rdy%0d", v, g), m_if.din_ready, 0);
        check($sformatf("tbl%0d_gap_lst%0d", v, g), m_if.last,      0);
      end
      @(negedge clock);
      check($sformatf("tbl%0d_idle_rdy", v), m_if.din_ready, 1);
    end

    // Back-to-back with GAP=0: FF then 00, din_valid held.
    wait_ready(2);
    z_if.din_valid = 1'b1; z_if.din = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (i == 0) z_if.din = 8'h00;
      if (i == 8) z_if.din_valid = 1'b0;
      check($sformatf("b2b_a%0d", i),    z_if.a,         (i < 8) ? 1 : 0);
      check($sformatf("b2b_av%0d", i),   z_if.a_valid,   1);
      check($sformatf("b2b_last%0d", i), z_if.last,      (i == 7 || i == 15) ? 1 : 0);
      check($sformatf("b2b_rdy%0d", i),  z_if.din_ready, (i == 7 || i == 15) ? 1 : 0);
    end
    @(negedge clock);
    check("b2b_end_av",  z_if.a_valid,   0);
    check("b2b_end_rdy", z_if.din_ready, 1);

    // Backpressure: 0F offered during SHIFT and GAP, accepted only in IDLE.
    wait_ready(0);
    w  = 8'h3C;
    w2 = 8'h0F;
    m_if.din_valid = 1'b1; m_if.din = w;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 0) m_if.din = w2;
      check($sformatf("bp_a%0d", i),   m_if.a,         w[7-i]);
      check($sformatf("bp_rdy%0d", i), m_if.din_ready, 0);
    end
    for (int g = 0; g < 2; g++) begin
      @(negedge clock);
      check($sformatf("bp_gap_av%0d", g), m_if.a_valid, 0);
    end
    @(negedge clock);
    check("bp_idle_rdy", m_if.din_ready, 1);
    check("bp_idle_av",  m_if.a_valid,   0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 0) m_if.din_valid = 1'b0;
      check($sformatf("bp2_a%0d", i),  m_if.a,       w2[7-i]);
      check($sformatf("bp2_av%0d", i), m_if.a_valid, 1);
    end
    repeat (3) @(negedge clock);

    // Reset mid-word after 3 bits of A5.
    wait_ready(0);
    w = 8'hA5;
    m_if.din_valid = 1'b1; m_if.din = w;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (i == 0) m_if.din_valid = 1'b0;
      check($sformatf("mr_a%0d", i), m_if.a, w[7-i]);
    end
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("mr_rst_a",   m_if.a,         0);
    check("mr_rst_av",  m_if.a_valid,   0);
    check("mr_rst_lst", m_if.last,      0);
    check("mr_rst_rdy", m_if.din_ready, 0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check($sformatf("mr_post_a%0d", i),  m_if.a,       0);
      check($sformatf("mr_post_av%0d", i), m_if.a_valid, 0);
    end
    check("mr_post_rdy", m_if.din_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
